// File: rtl/bidir_pad_arbiter_if.sv
// Request/response and pad-bank signals shared by the two local requesters,
// the pad ring and bidir_pad_arbiter.
interface bidir_pad_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             REQ0;
  logic             REQ1;
  logic             WE0;
  logic             WE1;
  logic [WIDTH-1:0] WDATA0;
  logic [WIDTH-1:0] WDATA1;
  logic             ACK0;
  logic             ACK1;
  logic [WIDTH-1:0] RDATA;
  logic [WIDTH-1:0] PAD_I;
  logic             PAD_T;
  logic [WIDTH-1:0] PAD_O;

  modport master (
    output REQ0, REQ1, WE0, WE1, WDATA0, WDATA1, PAD_O,
    input  ACK0, ACK1, RDATA, PAD_I, PAD_T
  );

  modport slave (
    input  REQ0, REQ1, WE0, WE1, WDATA0, WDATA1, PAD_O,
    output ACK0, ACK1, RDATA, PAD_I, PAD_T
  );
endinterface

// File: rtl/bidir_pad_arbiter.sv
// Two-requester arbiter for a bidirectional pad bank: round-robin grant,
// high-Z turnaround on every direction change, registered pad/ack outputs.
module bidir_pad_arbiter #(
  parameter int WIDTH      = 8,
  parameter int TURN_CYC   = 2,
  parameter int SAMPLE_CYC = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  bidir_pad_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TURN   = 2'd1;
  localparam logic [1:0] S_DRIVE  = 2'd2;
  localparam logic [1:0] S_SAMPLE = 2'd3;

  localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);
  localparam logic [3:0] SAMPLE_LD = 4'(SAMPLE_CYC - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_last_dir;
  logic             r_ptr;
  logic             r_pad_t;
  logic [WIDTH-1:0] r_pad_i;
  logic             r_ack0;
  logic             r_ack1;
  logic [WIDTH-1:0] r_rdata;
  logic             r_we;
  logic             r_id;
  logic [WIDTH-1:0] r_wdata;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant;
  logic             w_gid;
  logic             w_gwe;
  logic [WIDTH-1:0] w_gwdata;
  logic             w_done;
  logic             w_capture;
  logic [1:0]       w_state_nx;
  logic [3:0]       w_cnt_nx;
  logic [WIDTH-1:0] w_drive_data;

  always_comb begin
    // A requester still seeing its own ACK is presenting the next transaction;
    // it waits one cycle so the other requester gets a turn.
    w_elig0      = bus.REQ0 & ~r_ack0;
    w_elig1      = bus.REQ1 & ~r_ack1;
    w_grant      = (r_state == S_IDLE) && (w_elig0 || w_elig1);
    w_gid        = (w_elig0 && w_elig1) ? r_ptr : w_elig1;
    w_gwe        = w_gid ? bus.WE1 : bus.WE0;
    w_gwdata     = w_gid ? bus.WDATA1 : bus.WDATA0;
    w_capture    = (r_state == S_SAMPLE) && (r_cnt == 4'd0);
    w_done       = (r_state == S_DRIVE) || w_capture;
    w_drive_data = (r_state == S_IDLE) ? w_gwdata : r_wdata;
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          if (w_gwe != r_last_dir) begin
            w_state_nx = S_TURN;
            w_cnt_nx   = TURN_LD;
          end else if (w_gwe) begin
            w_state_nx = S_DRIVE;
          end else begin
            w_state_nx = S_SAMPLE;
            w_cnt_nx   = SAMPLE_LD;
          end
        end
      end
      S_TURN: begin
        if (r_cnt == 4'd0) begin
          if (r_we) begin
            w_state_nx = S_DRIVE;
          end else begin
            w_state_nx = S_SAMPLE;
            w_cnt_nx   = SAMPLE_LD;
          end
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_DRIVE: w_state_nx = S_IDLE;
      S_SAMPLE: begin
        if (r_cnt == 4'd0) w_state_nx = S_IDLE;
        else               w_cnt_nx   = r_cnt - 4'd1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Control and registered outputs; PAD_T is derived from the next state so it
  // lines up with the state it describes.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_last_dir <= 1'b0;
      r_ptr      <= 1'b0;
      r_pad_t    <= 1'b1;
      r_pad_i    <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pad_t <= (w_state_nx != S_DRIVE);
      r_ack0  <= w_done & ~r_id;
      r_ack1  <= w_done &  r_id;
      if (w_state_nx == S_DRIVE) r_pad_i <= w_drive_data;
      if (w_capture)             r_rdata <= bus.PAD_O;
      if (r_state == S_DRIVE)    r_last_dir <= 1'b1;
      else if (w_capture)        r_last_dir <= 1'b0;
      if (w_grant)               r_ptr <= ~w_gid;
    end
  end

  // Granted transaction payload
  always_ff @(posedge CLK) begin
    if (w_grant) begin
      r_we    <= w_gwe;
      r_id    <= w_gid;
      r_wdata <= w_gwdata;
    end
  end

  assign bus.PAD_T = r_pad_t;
  assign bus.PAD_I = r_pad_i;
  assign bus.ACK0  = r_ack0;
  assign bus.ACK1  = r_ack1;
  assign bus.RDATA = r_rdata;

endmodule

// File: doc/bidir_pad_arbiter.md
# bidir_pad_arbiter

Sequences a WIDTH-bit bank of bidirectional tristate pad buffers and shares it between two on-chip requesters, each issuing single-word writes or reads.
- Owns the pad bank's enable (T, 1 = high-Z), output data (I) and input sample (O).
- Guarantees turnaround gaps on every change of bus direction.
- Sits between the pad ring and the local bus masters.

## Interface
Parameters:
- WIDTH, 8, pad bank and data width.
- TURN_CYC, 2, high-Z turnaround cycles inserted on direction change; legal 1..15.
- SAMPLE_CYC, 2, cycles the bus is held high-Z before PAD_O is captured on a read; legal 1..15.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- REQ0, REQ1  in  1  transaction request, requester 0/1.
- WE0, WE1  in  1  1 = write, 0 = read; qualified by REQx.
- WDATA0, WDATA1  in  WIDTH  write data; qualified by REQx & WEx.
- ACK0, ACK1  out  1  one-cycle completion pulse.
- RDATA  out  WIDTH  read data; valid while the ACK of a read is high; held until the next read capture.
- PAD_I  out  WIDTH  to the pad buffers' I.
- PAD_T  out  1  to the pad buffers' T; 1 = high-Z.
- PAD_O  in  WIDTH  from the pad buffers' O.

## Operation
- States: IDLE, TURN, DRIVE, SAMPLE.
- All outputs are registered.
- Reset values:
  - PAD_T = 1, PAD_I = 0, ACK0 = ACK1 = 0, RDATA = 0.
  - state = IDLE, last_dir = READ, round-robin pointer favors requester 0.
- IDLE (PAD_T = 1):
  - Arbitrate among REQx.
  - A requester whose ACKx is high this cycle is excluded from arbitration.
  - If both requesters are eligible, grant the one the pointer favors. The pointer then favors the other requester.
  - If only one is eligible, grant it. The pointer then favors the other requester.
  - On grant, latch the granted WE, WDATA and requester id.
  - If the granted direction differs from last_dir, go to TURN; otherwise go to DRIVE (write) or SAMPLE (read).
- TURN: PAD_T = 1 for exactly TURN_CYC cycles, then DRIVE or SAMPLE.
- DRIVE:
  - Exactly 1 cycle, with PAD_T = 0 and PAD_I = the latched WDATA.
  - Set last_dir = WRITE, then go to IDLE with ACKx = 1.
- SAMPLE:
  - PAD_T = 1 for SAMPLE_CYC cycles.
  - On the edge ending the last SAMPLE cycle, RDATA <= PAD_O.
  - Set last_dir = READ, then go to IDLE with ACKx = 1.
- PAD_I:
  - Holds its last driven value outside DRIVE.
  - Is a don't-care when PAD_T = 1, but must not toggle.
- Requester rules:
  - Hold REQx, WEx and WDATAx stable until ACKx is sampled high.
  - On that edge, deassert REQx or present a new transaction.
- REQx may drop before grant; the request is then withdrawn with no ACK.
- After grant, the transaction completes regardless of REQx.
- Every transaction returns through IDLE. The minimum gap between two same-direction transactions is 1 IDLE cycle.
- Reset asserted mid-transaction:
  - Outputs go to their reset values on the next edge: PAD_T = 1 and no ACK.
  - The transaction is dropped.

## Timing
Cycle 0 is the IDLE cycle in which the grant occurs.
- Write, same direction: DRIVE in cycle 1; ACK in cycle 2.
- Write after a read, or the first write after reset: TURN in cycles 1..TURN_CYC, DRIVE in cycle TURN_CYC+1, ACK in cycle TURN_CYC+2.
- Read, same direction: SAMPLE in cycles 1..SAMPLE_CYC; RDATA updates and ACK rises in cycle SAMPLE_CYC+1.
- Read after a write: TURN in cycles 1..TURN_CYC, SAMPLE in the next SAMPLE_CYC cycles, then ACK.
- PAD_T is 0 in DRIVE cycles only.
- No cycle has PAD_T = 0 adjacent to a SAMPLE cycle: at least TURN_CYC high-Z cycles separate them.
- Simultaneous REQ0 and REQ1 from reset: requester 0 is served first, then requester 1 with no starvation. Each gets at most one transaction while the other is pending.

## Test plan
- Reset with REQ0 = REQ1 = 0 -> PAD_T = 1, PAD_I = 0, RDATA = 0, ACK0 = ACK1 = 0 for 10 cycles.
- From reset, REQ0 write 0xA5 (TURN_CYC = 2) -> PAD_T = 1 in cycles 1–2; PAD_T = 0 with PAD_I = 0xA5 in cycle 3 only; ACK0 in cycle 4. A second write 0x3C then shows DRIVE 1 cycle after grant.
- REQ1 read with the bus model driving PAD_O = 0x5A (SAMPLE_CYC = 2), preceded by a write -> 2 TURN cycles, 2 SAMPLE cycles with PAD_T = 1, then RDATA = 0x5A with ACK1 high. RDATA is still 0x5A 5 cycles later.
- REQ0 and REQ1 both holding write requests continuously -> grants alternate 0, 1, 0, 1 over 8 transactions. ACK0 and ACK1 are never high together.
- Interleaved write/read/write from one requester -> every DRIVE is separated from any SAMPLE by at least 2 PAD_T = 1 TURN cycles. A checker flags any PAD_T = 0 cycle adjacent to SAMPLE.
- RST_N low during the DRIVE cycle of a write -> PAD_T = 1 at the next edge and no ACK. After release, the first write again incurs TURN_CYC turnaround.
